// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers for the EX stage
// Ports:
//   clk      pipeline clock
//   reset    synchronous active-high reset, dominates every other input
//   StartE   EX-stage instruction is an MD operation this cycle
//   MDOpE    000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 none
//   AE, BE   forwarded rs / rt operands in EX
//   MDUseD   D-stage instruction touches the MD unit (incl. mfhi/mflo)
//   Busy     multi-cycle operation in progress
//   HI, LO   architectural HI/LO registers, readable combinationally
//   MDStallD stall request ORed into StallF/StallD/FlushE by the hazard unit
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        StartE,
   input  logic [2:0]  MDOpE,
   input  logic [31:0] AE,
   input  logic [31:0] BE,
   input  logic        MDUseD,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic        MDStallD
);
   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW = $clog2(MAXC + 1);
   localparam logic [2:0] OP_MULT = 3'd1, OP_MULTU = 3'd2, OP_DIV = 3'd3,
                          OP_DIVU = 3'd4, OP_MTHI = 3'd5, OP_MTLO = 3'd6;

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [31:0]   pend_hi, pend_lo;
   logic          pend_wr;
   logic          commit;

   logic          long_op, div_op, accept;
   logic [63:0]   prod_s, prod_u, res;
   logic          a_neg, b_neg;
   logic [31:0]   a_mag, b_mag, b_safe, bu_safe;
   logic [31:0]   uq, ur, q_s, r_s, q_u, r_u;

   assign long_op = (MDOpE >= OP_MULT) && (MDOpE <= OP_DIVU);
   assign div_op  = (MDOpE == OP_DIV) || (MDOpE == OP_DIVU);
   assign accept  = StartE && !Busy && (MDOpE != 3'd0) && (MDOpE != 3'd7);

   assign Busy     = (state == RUN);
   assign MDStallD = MDUseD && (Busy || (StartE && long_op));

   // Products are formed as 64-bit unsigned multiplies of extended operands.
   assign prod_s = {{32{AE[31]}}, AE} * {{32{BE[31]}}, BE};
   assign prod_u = {32'd0, AE} * {32'd0, BE};

   // Signed divide via magnitudes so 0x80000000 / -1 wraps to 0x80000000 cleanly.
   // A zero divisor is replaced by 1 only to keep the datapath X-free; that
   // result is never committed.
   assign a_neg   = AE[31];
   assign b_neg   = BE[31];
   assign a_mag   = a_neg ? (~AE + 32'd1) : AE;
   assign b_mag   = b_neg ? (~BE + 32'd1) : BE;
   assign b_safe  = (BE == 32'd0) ? 32'd1 : b_mag;
   assign bu_safe = (BE == 32'd0) ? 32'd1 : BE;
   assign uq      = a_mag / b_safe;
   assign ur      = a_mag % b_safe;
   assign q_s     = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
   assign r_s     = a_neg ? (~ur + 32'd1) : ur;
   assign q_u     = AE / bu_safe;
   assign r_u     = AE % bu_safe;

   always_comb begin
      res = prod_s;
      case (MDOpE)
         OP_MULTU: res = prod_u;
         OP_DIV:   res = {r_s, q_s};
         OP_DIVU:  res = {r_u, q_u};
         default:  res = prod_s;
      endcase
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      commit  = 1'b0;
      if (state == IDLE) begin
         if (accept && long_op) begin
            state_n = RUN;
            cnt_n   = div_op ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
         end
      end else begin
         cnt_n = cnt - CW'(1);
         if (cnt == CW'(1)) begin
            state_n = IDLE;
            commit  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         pend_hi <= '0;
         pend_lo <= '0;
         pend_wr <= 1'b0;
         HI      <= '0;
         LO      <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (accept && long_op) begin
            pend_hi <= res[63:32];
            pend_lo <= res[31:0];
            pend_wr <= !(div_op && (BE == 32'd0));
         end
         // Accept requires !Busy and commit happens only in RUN, so the
         // move writes and the commit never collide.
         if (commit && pend_wr) begin
            HI <= pend_hi;
            LO <= pend_lo;
         end
         if (accept && MDOpE == OP_MTHI) HI <= AE;
         if (accept && MDOpE == OP_MTLO) LO <= AE;
      end
   end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: self-checking bench for md_unit against a longint reference model
module tb_md_unit;
   logic        clk = 0;
   logic        reset = 1;
   logic        StartE = 0;
   logic [2:0]  MDOpE = 0;
   logic [31:0] AE = 0, BE = 0;
   logic        MDUseD = 0;
   logic        Busy, MDStallD;
   logic [31:0] HI, LO;

   int total = 0;
   int bad = 0;
   logic [31:0] m_hi = 0, m_lo = 0;

   md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .StartE(StartE), .MDOpE(MDOpE), .AE(AE), .BE(BE),
      .MDUseD(MDUseD), .Busy(Busy), .HI(HI), .LO(LO), .MDStallD(MDStallD)
   );

   always #5 clk = ~clk;

   function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, p;
      logic [63:0] pu;
      sa = $signed(a);
      sb = $signed(b);
      case (op)
         3'd1: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
         3'd2: begin pu = {32'd0, a} * {32'd0, b}; m_hi = pu[63:32]; m_lo = pu[31:0]; end
         3'd3: if (b != 0) begin p = sa / sb; m_lo = p[31:0]; p = sa % sb; m_hi = p[31:0]; end
         3'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
         3'd5: m_hi = a;
         3'd6: m_lo = a;
         default: ;
      endcase
   endfunction

   function automatic int exp_busy(input logic [2:0] op);
      return (op == 3'd1 || op == 3'd2) ? 5 : (op == 3'd3 || op == 3'd4) ? 10 : 0;
   endfunction

   // Issues one operation and observes the busy period and stall behaviour.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic use_d, output int cycles, output logic stall_ok);
      @(negedge clk);
      StartE = 1; MDOpE = op; AE = a; BE = b; MDUseD = use_d;
      #1 stall_ok = (MDStallD === (use_d && op >= 3'd1 && op <= 3'd4));
      @(negedge clk);
      StartE = 0; MDOpE = 0; AE = $urandom; BE = $urandom;
      #1 cycles = 0;
      while (Busy === 1'b1 && cycles < 100) begin
         if (MDStallD !== use_d) stall_ok = 0;
         cycles++;
         @(negedge clk);
         #1;
      end
      if (MDStallD !== 1'b0) stall_ok = 0;
      MDUseD = 0;
   endtask

   task automatic test_reset();
      reset = 1;
      repeat (3) @(negedge clk);
      #1;
      total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", Busy); end
      total++; if ({HI, LO} !== 64'd0) begin bad++; $display("FAIL reset_hilo got %h want 0", {HI, LO}); end
      total++; if (MDStallD !== 1'b0) begin bad++; $display("FAIL reset_stall got %b want 0", MDStallD); end
      reset = 0;
   endtask

   task automatic test_directed();
      logic [2:0]  op[5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd3};
      logic [31:0] a[5]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd7, 32'h80000000};
      logic [31:0] b[5]  = '{32'd2, 32'd2, 32'd2, 32'd2, 32'hFFFFFFFF};
      logic [31:0] eh[5] = '{32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF, 32'd1, 32'd0};
      logic [31:0] el[5] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd3, 32'h80000000};
      int cy;
      logic sok;
      for (int i = 0; i < 5; i++) begin
         run_op(op[i], a[i], b[i], i[0], cy, sok);
         model(op[i], a[i], b[i]);
         total++; if (cy != exp_busy(op[i])) begin bad++; $display("FAIL dir%0d_busy got %0d want %0d", i, cy, exp_busy(op[i])); end
         total++; if (HI !== eh[i]) begin bad++; $display("FAIL dir%0d_hi got %h want %h", i, HI, eh[i]); end
         total++; if (LO !== el[i]) begin bad++; $display("FAIL dir%0d_lo got %h want %h", i, LO, el[i]); end
         total++; if (sok !== 1'b1) begin bad++; $display("FAIL dir%0d_stall got %b want 1", i, sok); end
      end
   endtask

   task automatic test_move_divzero();
      int cy;
      logic sok;
      run_op(3'd5, 32'h1234, 32'h0, 1'b1, cy, sok);
      total++; if (cy != 0 || HI !== 32'h1234) begin bad++; $display("FAIL mthi got busy=%0d hi=%h want busy=0 hi=1234", cy, HI); end
      total++; if (sok !== 1'b1) begin bad++; $display("FAIL mthi_stall got %b want 1", sok); end
      run_op(3'd6, 32'h5678, 32'h0, 1'b0, cy, sok);
      total++; if (cy != 0 || LO !== 32'h5678) begin bad++; $display("FAIL mtlo got busy=%0d lo=%h want busy=0 lo=5678", cy, LO); end
      run_op(3'd3, 32'h99, 32'h0, 1'b1, cy, sok);
      total++; if (cy != 10) begin bad++; $display("FAIL divzero_busy got %0d want 10", cy); end
      total++; if ({HI, LO} !== {32'h1234, 32'h5678}) begin bad++; $display("FAIL divzero_hilo got %h want %h", {HI, LO}, {32'h1234, 32'h5678}); end
      total++; if (sok !== 1'b1) begin bad++; $display("FAIL divzero_stall got %b want 1", sok); end
      m_hi = 32'h1234; m_lo = 32'h5678;
   endtask

   task automatic test_reserved();
      @(negedge clk);
      StartE = 1; MDOpE = 3'd7; AE = 32'hDEAD; BE = 32'h3; MDUseD = 1;
      #1;
      total++; if (MDStallD !== 1'b0) begin bad++; $display("FAIL reserved_stall got %b want 0", MDStallD); end
      @(negedge clk);
      MDOpE = 3'd0;
      #1;
      total++; if (Busy !== 1'b0 || {HI, LO} !== {m_hi, m_lo}) begin bad++; $display("FAIL reserved_state got busy=%b %h want 0 %h", Busy, {HI, LO}, {m_hi, m_lo}); end
      StartE = 0; MDUseD = 0;
   endtask

   task automatic test_busy_start();
      int cy = 0;
      logic sok = 1;
      @(negedge clk);
      StartE = 1; MDOpE = 3'd1; AE = 32'd3; BE = 32'd4; MDUseD = 1;
      @(negedge clk);
      StartE = 0; MDOpE = 0;
      repeat (2) begin #1 if (Busy === 1'b1) cy++; @(negedge clk); end
      StartE = 1; MDOpE = 3'd3; AE = 32'd100; BE = 32'd7;
      #1 if (MDStallD !== 1'b1) sok = 0;
      if (Busy === 1'b1) cy++;
      @(negedge clk);
      StartE = 0; MDOpE = 0;
      #1;
      while (Busy === 1'b1 && cy < 100) begin cy++; @(negedge clk); #1; end
      MDUseD = 0;
      model(3'd1, 32'd3, 32'd4);
      total++; if (cy != 5) begin bad++; $display("FAIL busy_start_cycles got %0d want 5", cy); end
      total++; if ({HI, LO} !== {m_hi, m_lo}) begin bad++; $display("FAIL busy_start_hilo got %h want %h", {HI, LO}, {m_hi, m_lo}); end
      total++; if (sok !== 1'b1) begin bad++; $display("FAIL busy_start_stall got %b want 1", sok); end
   endtask

   task automatic test_reset_mid();
      int hi_cnt = 0;
      @(negedge clk);
      StartE = 1; MDOpE = 3'd1; AE = 32'hFFFFFFFF; BE = 32'd2;
      @(negedge clk);
      StartE = 0; MDOpE = 0;
      repeat (2) @(negedge clk);
      reset = 1;
      @(negedge clk);
      reset = 0;
      #1;
      total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_mid_busy got %b want 0", Busy); end
      total++; if ({HI, LO} !== 64'd0) begin bad++; $display("FAIL reset_mid_hilo got %h want 0", {HI, LO}); end
      repeat (12) begin @(negedge clk); #1 if (Busy !== 1'b0 || {HI, LO} !== 64'd0) hi_cnt++; end
      total++; if (hi_cnt != 0) begin bad++; $display("FAIL reset_mid_commit got %0d bad cycles want 0", hi_cnt); end
      m_hi = 0; m_lo = 0;
   endtask

   task automatic test_random();
      logic [2:0]  op;
      logic [31:0] a, b;
      logic        u;
      int cy;
      logic sok;
      for (int i = 0; i < 60; i++) begin
         op = 3'($urandom_range(1, 6));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 5))
            0: b = 0;
            1: b = 32'hFFFFFFFF;
            2: a = 32'h80000000;
            3: b = 32'($urandom_range(1, 9));
            default: ;
         endcase
         u = 1'($urandom);
         run_op(op, a, b, u, cy, sok);
         model(op, a, b);
         total++; if (cy != exp_busy(op) || {HI, LO} !== {m_hi, m_lo} || sok !== 1'b1)
            begin bad++; $display("FAIL rnd%0d op=%0d a=%h b=%h got busy=%0d %h stall_ok=%b want busy=%0d %h", i, op, a, b, cy, {HI, LO}, sok, exp_busy(op), {m_hi, m_lo}); end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_move_divzero();
      test_reserved();
      test_busy_start();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
